// File: rtl/poly_term_sched_if.sv
// Configuration, operand and result signals of the polynomial term scheduler.
interface poly_term_sched_if;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [23:0] cfg_coef;
    logic [5:0]  cfg_exp;
    logic        cfg_num_we;
    logic [5:0]  cfg_num;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [7:0]  in3;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out1;
    logic [15:0] out2;
    logic        busy;

    modport master (
        output cfg_we, cfg_addr, cfg_coef, cfg_exp, cfg_num_we, cfg_num,
        output in_valid, in1, in2, in3, out_ready,
        input  cfg_err, in_ready, out_valid, out1, out2, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_coef, cfg_exp, cfg_num_we, cfg_num,
        input  in_valid, in1, in2, in3, out_ready,
        output cfg_err, in_ready, out_valid, out1, out2, busy
    );
endinterface

// File: rtl/poly_term_sched.sv
// Sequential polynomial evaluator: sum of coef*in1^e1*in2^e2*in3^e3 mod 2^24,
// all products formed one per cycle through a single shared 24x8 multiplier.
module poly_term_sched #(
    parameter int MAX_TERMS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    poly_term_sched_if.slave  bus
);
    localparam int AW = $clog2(MAX_TERMS);

    typedef enum logic [2:0] {IDLE, LOAD, INIT, MUL, ACC, DONE} state_t;

    state_t        state;
    logic [23:0]   coef_tab [MAX_TERMS];
    logic [5:0]    exp_tab  [MAX_TERMS];
    logic [5:0]    num_terms;
    logic [AW-1:0] idx;
    logic [7:0]    a1, a2, a3;
    logic [23:0]   acc, prod;
    logic [1:0]    c1, c2, c3;

    logic [23:0]   mul_a;
    logic [7:0]    mul_b;
    logic [31:0]   mul_p;
    logic          last_mul, last_term, idle;

    assign idle      = (state == IDLE);
    assign last_mul  = ({2'b0, c1} + {2'b0, c2} + {2'b0, c3}) == 4'd1;
    assign last_term = 6'(idx) == (num_terms - 6'd1);

    // Operand steering: in1*in3 during LOAD, otherwise prod times the
    // operand whose exponent counter is still pending (in1, then in2, then in3).
    always_comb begin
        mul_a = prod;
        mul_b = a3;
        if (state == LOAD) begin
            mul_a = {16'd0, a1};
            mul_b = a3;
        end else if (c1 != 2'd0) begin
            mul_b = a1;
        end else if (c2 != 2'd0) begin
            mul_b = a2;
        end
    end

    assign mul_p = {8'd0, mul_a} * {24'd0, mul_b};

    // Config writes only land while idle; a write in the accept cycle is
    // visible to the evaluation because the table is first read in INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_TERMS; i++) begin
                coef_tab[i] <= '0;
                exp_tab[i]  <= '0;
            end
            num_terms <= '0;
            bus.cfg_err <= 1'b0;
        end else begin
            bus.cfg_err <= ((bus.cfg_we || bus.cfg_num_we) && !idle) ||
                           (bus.cfg_num_we && idle && bus.cfg_num > 6'(MAX_TERMS));
            if (idle && bus.cfg_we) begin
                coef_tab[bus.cfg_addr] <= bus.cfg_coef;
                exp_tab[bus.cfg_addr]  <= bus.cfg_exp;
            end
            if (idle && bus.cfg_num_we && bus.cfg_num <= 6'(MAX_TERMS))
                num_terms <= bus.cfg_num;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            a1            <= '0;
            a2            <= '0;
            a3            <= '0;
            acc           <= '0;
            prod          <= '0;
            c1            <= '0;
            c2            <= '0;
            c3            <= '0;
            bus.out1      <= '0;
            bus.out2      <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a1           <= bus.in1;
                    a2           <= bus.in2;
                    a3           <= bus.in3;
                    acc          <= '0;
                    idx          <= '0;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b1;
                    state        <= LOAD;
                end
                LOAD: begin
                    bus.out2 <= mul_p[15:0];
                    if (num_terms == 6'd0) begin
                        bus.out1      <= acc;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        state <= INIT;
                    end
                end
                INIT: begin
                    prod         <= coef_tab[idx];
                    {c1, c2, c3} <= exp_tab[idx];
                    state        <= (exp_tab[idx] == 6'd0) ? ACC : MUL;
                end
                MUL: begin
                    prod <= mul_p[23:0];
                    if (c1 != 2'd0)      c1 <= c1 - 2'd1;
                    else if (c2 != 2'd0) c2 <= c2 - 2'd1;
                    else                 c3 <= c3 - 2'd1;
                    if (last_mul) state <= ACC;
                end
                ACC: begin
                    acc <= acc + prod;
                    if (last_term) begin
                        bus.out1      <= acc + prod;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= INIT;
                    end
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_term_sched.sv
// Directed scoreboard bench for poly_term_sched: stimulus queues expected
// results, a monitor checks latency and values when results are presented.
module tb_poly_term_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    poly_term_sched_if bus();
    poly_term_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [23:0] o1;
        logic [15:0] o2;
        int          lat;
        int          acyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: latency on first sight of out_valid, values on handshake.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.out_valid && !seen) begin
                if (q.size() == 0) chk("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
                else               chk("latency", cyc - q[0].acyc, q[0].lat);
                seen = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() > 0) begin
                    chk("out1", {8'd0, bus.out1}, {8'd0, q[0].o1});
                    chk("out2", {16'd0, bus.out2}, {16'd0, q[0].o2});
                    void'(q.pop_front());
                end
                seen = 1'b0;
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic cfg_wr(input logic [4:0] a, input logic [23:0] c, input logic [5:0] e);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_coef = c; bus.cfg_exp = e;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        chk("cfg_err_idle_write", {31'd0, bus.cfg_err}, 32'd0);
    endtask

    task automatic num_wr(input logic [5:0] n, input logic err);
        @(negedge clk);
        bus.cfg_num_we = 1'b1; bus.cfg_num = n;
        @(negedge clk);
        bus.cfg_num_we = 1'b0;
        chk("cfg_err_num_write", {31'd0, bus.cfg_err}, {31'd0, err});
    endtask

    task automatic eval(input logic [7:0] x1, x2, x3, input logic [23:0] o1,
                        input logic [15:0] o2, input int lat, input bit push);
        int t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
        chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1; bus.in1 = x1; bus.in2 = x2; bus.in3 = x3;
        if (push) q.push_back('{o1, o2, lat, cyc + 1});
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while ((q.size() != 0 || !bus.in_ready) && t < 500) begin @(negedge clk); t++; end
        chk("drain_queue_empty", q.size(), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_coef = 0; bus.cfg_exp = 0;
        bus.cfg_num_we = 0; bus.cfg_num = 0; bus.in_valid = 0;
        bus.in1 = 0; bus.in2 = 0; bus.in3 = 0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
        chk("rst_out1", {8'd0, bus.out1}, 32'd0);
        chk("rst_out2", {16'd0, bus.out2}, 32'd0);

        // num_terms = 0 right after reset
        eval(8'd5, 8'd7, 8'd9, 24'd0, 16'd45, 1, 1'b1);
        drain();

        // single cubic term
        cfg_wr(5'd0, 24'd1, 6'b11_00_00);
        num_wr(6'd1, 1'b0);
        eval(8'd200, 8'd0, 8'd10, 24'd8000000, 16'd2000, 6, 1'b1);
        drain();

        // two terms whose sum wraps to zero
        cfg_wr(5'd0, 24'd8388608, 6'b00_10_00);
        cfg_wr(5'd1, 24'd8388608, 6'b00_00_10);
        num_wr(6'd2, 1'b0);
        eval(8'd4, 8'd1, 8'd3, 24'd0, 16'd12, 9, 1'b1);
        drain();

        // negative coefficient
        cfg_wr(5'd0, 24'hFFFFFF, 6'b01_00_01);
        num_wr(6'd1, 1'b0);
        eval(8'd2, 8'd0, 8'd3, 24'hFFFFFA, 16'd6, 5, 1'b1);
        drain();

        // out-of-range term count is rejected, count stays 1
        num_wr(6'd40, 1'b1);
        eval(8'd1, 8'd0, 8'd1, 24'hFFFFFF, 16'd1, 5, 1'b1);
        drain();

        // backpressure: results hold, new operands and config are ignored
        bus.out_ready = 1'b0;
        eval(8'd3, 8'd0, 8'd5, 24'hFFFFF1, 16'd15, 5, 1'b1);
        t = 0;
        while (!bus.out_valid && t < 50) begin @(negedge clk); t++; end
        chk("hold_reached_done", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in1 = 8'd50 + 8'(i); bus.in2 = 8'd1; bus.in3 = 8'd2;
            if (i == 0) begin
                bus.cfg_we = 1'b1; bus.cfg_addr = 5'd0; bus.cfg_coef = 24'd123; bus.cfg_exp = 6'd0;
            end
            @(negedge clk);
            bus.cfg_we = 1'b0;
            chk("hold_out1", {8'd0, bus.out1}, 32'h00FFFFF1);
            chk("hold_out2", {16'd0, bus.out2}, 32'd15);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold_cfg_err", {31'd0, bus.cfg_err}, (i == 0) ? 32'd1 : 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        eval(8'd1, 8'd0, 8'd1, 24'hFFFFFF, 16'd1, 5, 1'b1);
        drain();

        // term-count write in the accept cycle applies first
        @(negedge clk);
        bus.cfg_num_we = 1'b1; bus.cfg_num = 6'd0;
        bus.in_valid = 1'b1; bus.in1 = 8'd6; bus.in2 = 8'd0; bus.in3 = 8'd7;
        q.push_back('{24'd0, 16'd42, 1, cyc + 1});
        @(negedge clk);
        bus.cfg_num_we = 1'b0; bus.in_valid = 1'b0;
        chk("same_cycle_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
        drain();

        // reset in the middle of MUL aborts with no result
        cfg_wr(5'd0, 24'd1, 6'b11_00_00);
        num_wr(6'd1, 1'b0);
        eval(8'd200, 8'd0, 8'd10, 24'd0, 16'd0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_mid_mul", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_out1", {8'd0, bus.out1}, 32'd0);
        chk("abort_out2", {16'd0, bus.out2}, 32'd0);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        eval(8'd5, 8'd7, 8'd9, 24'd0, 16'd45, 1, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/poly_term_sched.md
POLY_TERM_SCHED -- requirements
Module: poly_term_sched

Interface
REQ-001 Parameter: MAX_TERMS, 32, depth of term table (address width 5).
REQ-002 The block SHALL use one clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-003 Ports (name direction width meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- cfg_we  in  1  term-table write strobe
- cfg_addr  in  5  term index
- cfg_coef  in  24  term coefficient, two's complement, mod 2^24
- cfg_exp  in  6  exponents {e1[5:4], e2[3:2], e3[1:0]}, each 0..3
- cfg_num_we  in  1  term-count write strobe
- cfg_num  in  6  active term count, 0..32
- cfg_err  out  1  one-cycle pulse on a rejected config write
- in_valid  in  1  operand handshake valid
- in_ready  out  1  operand handshake ready
- in1, in2, in3  in  8 each  unsigned operands
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out1  out  24  polynomial result, sum of coef*in1^e1*in2^e2*in3^e3 mod 2^24
- out2  out  16  in1*in3, unsigned
- busy  out  1  high in every state except IDLE

Function
REQ-004 The block SHALL contain exactly one shared 24x8 multiplier; every product SHALL be formed through it, one product per cycle.
REQ-005 States: IDLE, LOAD, INIT, MUL, ACC, DONE.
REQ-006 IDLE: in_ready=1. On in_valid&in_ready, the block SHALL capture in1..in3, clear acc, set the term index to 0, and go to LOAD.
REQ-007 LOAD (1 cycle): out2 <= in1*in3 via the multiplier. If num_terms=0, go to DONE; otherwise go to INIT.
REQ-008 INIT (1 cycle): prod <= coef[idx]; load exponent counters. If e1+e2+e3=0, go to ACC; otherwise go to MUL.
REQ-009 MUL: one cycle per unit of exponent, ordered in1 (e1 times), then in2, then in3; each cycle prod <= (prod*operand) mod 2^24. After the last multiply, go to ACC.
REQ-010 ACC (1 cycle): acc <= (acc+prod) mod 2^24. If idx=num_terms-1, go to DONE; otherwise idx++ and go to INIT.
REQ-011 DONE: out_valid=1 with out1=acc and out2 stable. On out_ready, go to IDLE. out1 and out2 SHALL hold until the next LOAD.
REQ-012 Latency from the accept edge to out_valid SHALL be 1 + sum over terms of (2+e1+e2+e3) cycles; for num_terms=0 it SHALL be 1.
REQ-013 in_ready SHALL be 0 in all states except IDLE; in_valid outside IDLE SHALL be ignored.
REQ-014 cfg_we and cfg_num_we SHALL take effect only while in IDLE. While busy they SHALL be ignored, cause a cfg_err pulse on the next cycle, and leave the table unchanged.
REQ-015 cfg_num>32 SHALL be rejected with a cfg_err pulse, and num_terms SHALL be unchanged.
REQ-016 A cfg write and an in_valid accept in the same IDLE cycle: the write SHALL apply first; the evaluation SHALL use the new value.
REQ-017 All arithmetic SHALL wrap mod 2^24, with no saturation and no overflow flag.
REQ-018 Table entries at idx >= num_terms SHALL NOT be read.

Reset
REQ-019 On rst_n low, asynchronously: state=IDLE; out1=0, out2=0, out_valid=0, cfg_err=0, busy=0, acc=0, prod=0, num_terms=0; all coef and exp entries=0.
REQ-020 After rst_n release, in_ready SHALL be 1 on the first clock.
REQ-021 Reset asserted in any state, including mid-MUL, SHALL abort the evaluation with no out_valid pulse.

Verification
REQ-022 After reset, with num_terms=0: in1=5, in2=7, in3=9 -> out_valid 1 cycle after accept, out1=0, out2=45.
REQ-023 One term, coef=1, exp=(3,0,0), in1=200, in3=10 -> out1=8000000, out2=2000, latency 6 cycles.
REQ-024 Terms coef=8388608 with exp=(0,2,0) and (0,0,2), in2=1, in3=3 -> out1=0 (wrap), latency 9 cycles.
REQ-025 coef=0xFFFFFF, exp=(1,0,1), in1=2, in3=3 -> out1=0xFFFFFA.
REQ-026 Hold out_ready=0 for 5 cycles while in_valid=1 with new operands -> out1/out2 stable, in_ready=0, and a cfg_we in the same window pulses cfg_err with the table unchanged.
REQ-027 Assert rst_n=0 during MUL -> all outputs 0 and state IDLE; a following evaluation with num_terms=0 gives out1=0.
